// File: rtl/rx_adc_pkg.sv
// Shared types and constants for the RX ADC deframer.
// Frame layout: I_SYNC, 7 I dibits, Q_SYNC, 7 Q dibits (16 dibits, MSB first).
package rx_adc_pkg;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        I_DATA = 3'd1,
        Q_HEAD = 3'd2,
        Q_DATA = 3'd3,
        I_HEAD = 3'd4
    } rx_state_t;

    localparam logic [1:0] I_SYNC = 2'b10;
    localparam logic [1:0] Q_SYNC = 2'b01;

    localparam int FRAME_DIBITS = 16;

    // Config/status register bit positions
    localparam int REG_RX_EN_BIT   = 0;
    localparam int REG_ERR_CLR_BIT = 1;
    localparam int REG_ERR_LSB     = 3;
    localparam int REG_LOCKED_BIT  = 7;

endpackage

// File: rtl/rx_iq_shift14.sv
// 14-bit dibit shift register: each enabled edge shifts the new dibit in at
// the LSB end, so after 7 loads the first dibit received sits in [13:12].
module rx_iq_shift14 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [1:0]  din,
    output logic [13:0] q
);

    // Shift the received dibit in, MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= {q[11:0], din};
        end
    end

endmodule

// File: rtl/rx_adc_deframer.sv
// RX ADC deframer: aligns to the 16-dibit LVDS I/Q frame, tracks lock and
// emits parallel 13-bit I/Q samples plus the two control bits.
// Optional feature macro: RX_ADC_ERR_CNT_EN enables the 4-bit sync error
// counter in status bits [6:3]; without it those bits read 0 and err_clr
// is ignored.
//
// Output handshake: iq_valid is a single-cycle pulse with no backpressure;
// iq_i/iq_q/iq_ctrl change only together with the pulse and hold otherwise.
module rx_adc_deframer
    import rx_adc_pkg::*;
#(
    parameter int LOCK_FRAMES  = 2,
    parameter int FIELD_DIBITS = (FRAME_DIBITS - 2) / 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  adcreg_data_in,
    output logic [7:0]  adcreg_data_out,
    input  logic [1:0]  from_lvds,
    output logic [12:0] iq_i,
    output logic [12:0] iq_q,
    output logic [1:0]  iq_ctrl,
    output logic        iq_valid,
    output logic        locked,
    output logic        sync_err
);

    rx_state_t   state;
    logic [2:0]  cnt;
    logic [2:0]  good_cnt;
    logic        rx_en;
    logic [3:0]  err_cnt;
    logic [13:0] i_field;
    logic [13:0] q_field;

    logic        last_dibit;
    logic        hdr_err;
    logic        err_clr;
    logic        i_load;
    logic        q_load;
    logic        frame_done;

    assign last_dibit = (cnt == 3'(FIELD_DIBITS - 1));
    assign err_clr    = wr_en & adcreg_data_in[REG_ERR_CLR_BIT];
    assign i_load     = rx_en && (state == I_DATA);
    assign q_load     = rx_en && (state == Q_DATA);
    assign frame_done = q_load && last_dibit;

    // Header check: only the two header slots can raise a sync error
    always_comb begin
        hdr_err = 1'b0;
        if (rx_en) begin
            if (state == Q_HEAD && from_lvds != Q_SYNC) hdr_err = 1'b1;
            if (state == I_HEAD && from_lvds != I_SYNC) hdr_err = 1'b1;
        end
    end

    rx_iq_shift14 u_i_shift (
        .clk   (clk),
        .reset (reset),
        .load  (i_load),
        .din   (from_lvds),
        .q     (i_field)
    );

    rx_iq_shift14 u_q_shift (
        .clk   (clk),
        .reset (reset),
        .load  (q_load),
        .din   (from_lvds),
        .q     (q_field)
    );

    // Framing FSM with lock tracking and registered sample outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            cnt      <= '0;
            good_cnt <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
            iq_valid <= 1'b0;
            iq_i     <= '0;
            iq_q     <= '0;
            iq_ctrl  <= '0;
        end else begin
            sync_err <= hdr_err;
            iq_valid <= frame_done && locked;
            // The last Q dibit is still on the pins, so it is merged directly
            if (frame_done && locked) begin
                iq_i    <= i_field[13:1];
                iq_q    <= {q_field[11:0], from_lvds[1]};
                iq_ctrl <= {i_field[0], from_lvds[0]};
            end
            if (!rx_en) begin
                state    <= HUNT;
                cnt      <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                if (hdr_err) begin
                    locked <= 1'b0;
                end else if (good_cnt == 3'(LOCK_FRAMES)) begin
                    locked <= 1'b1;
                end
                case (state)
                    HUNT: begin
                        if (from_lvds == I_SYNC) begin
                            state <= I_DATA;
                            cnt   <= '0;
                        end
                    end
                    I_DATA: begin
                        if (last_dibit) begin
                            state <= Q_HEAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    Q_HEAD: begin
                        if (from_lvds == Q_SYNC) begin
                            state <= Q_DATA;
                            if (good_cnt != 3'(LOCK_FRAMES)) good_cnt <= good_cnt + 3'd1;
                        end else begin
                            state    <= HUNT;
                            good_cnt <= '0;
                        end
                    end
                    Q_DATA: begin
                        if (last_dibit) begin
                            state <= I_HEAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    I_HEAD: begin
                        if (from_lvds == I_SYNC) begin
                            state <= I_DATA;
                        end else begin
                            state    <= HUNT;
                            good_cnt <= '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // Receive enable register bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_en <= 1'b0;
        end else if (wr_en) begin
            rx_en <= adcreg_data_in[REG_RX_EN_BIT];
        end
    end

`ifdef RX_ADC_ERR_CNT_EN
    // Saturating sync error counter; a clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (hdr_err && err_cnt != 4'hF) begin
            err_cnt <= err_cnt + 4'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, adcreg_data_in[7:2], q_field[13:12]};
`else
    assign err_cnt = 4'h0;

    logic unused_bits;
    assign unused_bits = &{1'b0, adcreg_data_in[7:2], q_field[13:12], err_clr};
`endif

    // Status readback, combinational and gated by rd_en
    always_comb begin
        adcreg_data_out = 8'h00;
        if (rd_en) begin
            adcreg_data_out[REG_LOCKED_BIT]             = locked;
            adcreg_data_out[REG_ERR_LSB + 3:REG_ERR_LSB] = err_cnt;
            adcreg_data_out[REG_RX_EN_BIT]              = rx_en;
        end
    end

endmodule

// File: tb/tb_rx_adc_deframer.sv
// Testbench for rx_adc_deframer: frame-position reference model feeding a
// sample scoreboard, plus status register checks at chosen points.
module tb_rx_adc_deframer;

    localparam int LOCK = 2;

    logic        clk;
    logic        reset;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  adcreg_data_in;
    logic [7:0]  adcreg_data_out;
    logic [1:0]  from_lvds;
    logic [12:0] iq_i;
    logic [12:0] iq_q;
    logic [1:0]  iq_ctrl;
    logic        iq_valid;
    logic        locked;
    logic        sync_err;

    rx_adc_deframer #(.LOCK_FRAMES(LOCK)) dut (
        .clk             (clk),
        .reset           (reset),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .adcreg_data_in  (adcreg_data_in),
        .adcreg_data_out (adcreg_data_out),
        .from_lvds       (from_lvds),
        .iq_i            (iq_i),
        .iq_q            (iq_q),
        .iq_ctrl         (iq_ctrl),
        .iq_valid        (iq_valid),
        .locked          (locked),
        .sync_err        (sync_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: m_pos is the frame index of the last captured
    // dibit, -1 while hunting for an I header.
    int  m_pos;
    int  m_good;
    bit  m_locked;
    bit  m_rx_en;
    int  m_err;
    int  i_acc;
    int  q_acc;
    int  exp_se_total;
    int  obs_se_total;
    int  obs_valid;
    logic [27:0] exp_q[$];
    logic [27:0] last_exp;
    logic [27:0] last_act;
    logic [1:0]  fr[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = -1; m_good = 0; m_locked = 0; m_rx_en = 0; m_err = 0;
        i_acc = 0; q_acc = 0;
        exp_q.delete();
    endtask

    // Effect of one clock edge with the given inputs
    function automatic void model_step(logic [1:0] d, bit w, logic [7:0] din);
        bit se;
        int old_good;
        bit old_locked;
        int nxt;
        se = 0;
        old_good = m_good;
        old_locked = m_locked;
        if (!m_rx_en) begin
            m_pos = -1; m_good = 0; m_locked = 0;
        end else begin
            if (m_pos < 0) begin
                if (d == 2'b10) m_pos = 0;
            end else begin
                nxt = (m_pos + 1) % 16;
                if (nxt == 0) begin
                    if (d != 2'b10) se = 1;
                end else if (nxt <= 7) begin
                    i_acc = (nxt == 1 ? 0 : i_acc) * 4 + int'(d);
                end else if (nxt == 8) begin
                    if (d == 2'b01) begin
                        if (m_good < LOCK) m_good++;
                    end else begin
                        se = 1;
                    end
                end else begin
                    q_acc = (nxt == 9 ? 0 : q_acc) * 4 + int'(d);
                    if (nxt == 15 && old_locked)
                        exp_q.push_back({13'(i_acc / 2), 13'(q_acc / 2), 1'(i_acc % 2), 1'(q_acc % 2)});
                end
                m_pos = se ? -1 : nxt;
            end
            if (se) begin
                m_good = 0; m_locked = 0; exp_se_total++;
            end else if (old_good == LOCK) begin
                m_locked = 1;
            end
        end
`ifdef RX_ADC_ERR_CNT_EN
        if (w && din[1]) m_err = 0;
        else if (se && m_err < 15) m_err++;
`endif
        if (w) m_rx_en = din[0];
    endfunction

    // Driver: one dibit per cycle, optional register write
    task automatic cyc(input logic [1:0] d, input bit w, input logic [7:0] din);
        @(negedge clk);
        from_lvds = d; wr_en = w; adcreg_data_in = din;
        model_step(d, w, din);
    endtask

    task automatic build_frame(input logic [13:0] iv, input logic [13:0] qv,
                               input logic [1:0] qh, input logic [1:0] ih);
        fr[0] = ih;
        fr[8] = qh;
        for (int k = 0; k < 7; k++) begin
            fr[1 + k] = iv[13 - 2 * k -: 2];
            fr[9 + k] = qv[13 - 2 * k -: 2];
        end
    endtask

    task automatic send_range(input int a, input int b);
        for (int k = a; k <= b; k++) cyc(fr[k], 1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [13:0] iv, input logic [13:0] qv,
                              input logic [1:0] qh, input logic [1:0] ih);
        build_frame(iv, qv, qh, ih);
        send_range(0, 15);
    endtask

    task automatic send_rand_frame(input bit allow_err);
        logic [1:0] qh;
        qh = (allow_err && $urandom_range(0, 9) == 0) ? 2'b11 : 2'b01;
        send_frame(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), qh, 2'b10);
    endtask

    // Let the pending edge happen, then compare status against the model
    task automatic check_status(input string tag);
        @(posedge clk);
        #2;
        rd_en = 1'b1;
        #1;
        check({tag, "_reg"}, 32'(adcreg_data_out),
              32'({m_locked, 4'(m_err), 2'b00, m_rx_en}));
        check({tag, "_locked"}, 32'(locked), 32'(m_locked));
        check({tag, "_sync_err_count"}, 32'(obs_se_total), 32'(exp_se_total));
        rd_en = 1'b0;
    endtask

    // Monitor: pop and compare every presented sample, count sync_err pulses
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (sync_err === 1'b1) obs_se_total++;
            if (iq_valid === 1'b1) begin
                last_act = {iq_i, iq_q, iq_ctrl};
                obs_valid++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_iq_valid: got sample 0x%0h expected no pulse", last_act);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("iq_sample", 32'(last_act), 32'(last_exp));
                end
            end
        end
    end

    int v0;

    initial begin
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; adcreg_data_in = 8'h00; from_lvds = 2'b00;
        exp_se_total = 0; obs_se_total = 0; obs_valid = 0;
        last_exp = '0; last_act = '0;
        model_reset();

        // Reset state
        #2;
        rd_en = 1'b1;
        #1;
        check("rst_reg", 32'(adcreg_data_out), 32'h0);
        check("rst_outputs", 32'({iq_i, iq_q, iq_ctrl, iq_valid, locked, sync_err}), 32'h0);
        rd_en = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Clean frames: first frame only acquires lock
        cyc(2'b00, 1'b1, 8'h01);
        v0 = obs_valid;
        repeat (3) send_frame(14'h1ABC, 14'h0246, 2'b01, 2'b10);
        check_status("t1");
        check("t1_valid_count", 32'(obs_valid - v0), 32'd2);
        check("t1_sample", 32'(last_act), 32'({13'h0D5E, 13'h0123, 2'b00}));

        // Corrupted Q header while locked, then relock
        build_frame(14'h0000, 14'h0000, 2'b11, 2'b10);
        send_range(0, 8);
        check_status("t2_err");
        check("t2_locked_dropped", 32'(locked), 32'd0);
        send_range(9, 15);
        repeat (3) send_frame(14'h1555, 14'h0F0F, 2'b01, 2'b10);
        check_status("t2_relock");

        // Hunt starting mid-frame with I_SYNC look-alikes in the data
        cyc(2'b00, 1'b1, 8'h00);
        repeat (3) cyc(2'b00, 1'b0, 8'h00);
        cyc(2'b00, 1'b1, 8'h01);
        build_frame(14'h2AAA, 14'h2AAA, 2'b01, 2'b10);
        send_range(3, 15);
        repeat (4) send_rand_frame(1'b0);
        check_status("t3");

        // Error counter saturation and clear
        repeat (20) send_frame(14'h0000, 14'h0000, 2'b11, 2'b10);
        check_status("t4_sat");
        cyc(2'b00, 1'b1, 8'h03);
        check_status("t4_clr");

        // rx_en drop inside Q data, then re-enable
        repeat (3) send_rand_frame(1'b0);
        build_frame(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 2'b01, 2'b10);
        send_range(0, 11);
        cyc(fr[12], 1'b1, 8'h00);
        send_range(13, 15);
        repeat (4) cyc(2'b00, 1'b0, 8'h00);
        check_status("t5_off");
        check("t5_hold", 32'({iq_i, iq_q, iq_ctrl}), 32'(last_exp));
        cyc(2'b00, 1'b1, 8'h01);
        repeat (3) send_rand_frame(1'b0);
        check_status("t5_relock");

        // Asynchronous reset mid-frame
        build_frame(14'h1ABC, 14'h0246, 2'b01, 2'b10);
        send_range(0, 4);
        @(posedge clk);
        #3;
        reset = 1'b1;
        rd_en = 1'b1;
        #1;
        check("t6_reg", 32'(adcreg_data_out), 32'h0);
        check("t6_outputs", 32'({iq_i, iq_q, iq_ctrl, iq_valid, locked, sync_err}), 32'h0);
        rd_en = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Randomized stream with occasional header corruption
        cyc(2'b00, 1'b1, 8'h01);
        repeat (30) send_rand_frame(1'b1);
        cyc(2'b00, 1'b0, 8'h00);
        check_status("final");
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
